// File: rtl/rotfpga2a_cfg_loader_pkg.sv
// Shared definitions for the rotfpga2a configuration loader: loader FSM
// state encoding and the grid scan-chain length used by the grid wrapper.
package rotfpga2a_cfg_loader_pkg;

    localparam int GRID_CHAIN_LEN = 144;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rotfpga2a_cfg_loader_deser.sv
// Readback deserialiser: collects bits leaving the scan chain LSB-first and
// emits a byte after every 8th bit, or early (zero-padded) on the last bit.
module rotfpga2a_cfg_loader_deser (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       sample,
    input  logic       last,
    input  logic       sdi,
    output logic [7:0] rd_data,
    output logic       rd_valid
);

    logic [7:0] acc;
    logic [2:0] cnt;
    logic [7:0] merged;

    // Current partial byte with the incoming bit dropped into its slot.
    always_comb begin
        merged      = acc;
        merged[cnt] = sdi;
    end

    // Accumulate sampled bits; publish on byte completion or final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= 8'd0;
            cnt      <= 3'd0;
            rd_data  <= 8'd0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (clear) begin
                acc <= 8'd0;
                cnt <= 3'd0;
            end else if (sample) begin
                if (cnt == 3'd7 || last) begin
                    rd_data  <= merged;
                    rd_valid <= 1'b1;
                    acc      <= 8'd0;
                    cnt      <= 3'd0;
                end else begin
                    acc <= merged;
                    cnt <= cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/rotfpga2a_cfg_loader.sv
// Byte-stream scan-chain loader: fetches configuration bytes over valid/ready,
// shifts them LSB-first into the grid chain with a per-bit strobe, and
// returns the bits leaving the chain as readback bytes.
module rotfpga2a_cfg_loader
    import rotfpga2a_cfg_loader_pkg::*;
#(
    parameter int CHAIN_LEN = GRID_CHAIN_LEN,
    parameter int CW        = $clog2(CHAIN_LEN + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       scan_en,
    output logic       scan_sdo,
    output logic       shift_stb,
    input  logic       scan_sdi,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [6:0]    data_q, data_d;
    logic          byte_ready_d, scan_en_d, scan_sdo_d, shift_stb_d;
    logic          busy_d, done_d, err_d;
    logic          abort_hit, rb_clear, rb_last, rb_sample;

    // Abort only matters while a load is in flight.
    assign abort_hit = abort && (state_q == ST_FETCH || state_q == ST_SHIFT);
    assign rb_clear  = abort_hit || (state_q == ST_IDLE && start);
    assign rb_last   = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT);
    assign rb_sample = shift_stb && !abort_hit;

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        bit_idx_d    = bit_idx_q;
        data_d       = data_q;
        err_d        = err;
        byte_ready_d = 1'b0;
        scan_en_d    = 1'b0;
        scan_sdo_d   = 1'b0;
        shift_stb_d  = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_FETCH;
                    bit_cnt_d    = '0;
                    bit_idx_d    = 3'd0;
                    err_d        = 1'b0;
                    byte_ready_d = 1'b1;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (byte_valid) begin
                    state_d     = ST_SHIFT;
                    data_d      = byte_data[7:1];
                    bit_idx_d   = 3'd0;
                    scan_en_d   = 1'b1;
                    shift_stb_d = 1'b1;
                    scan_sdo_d  = byte_data[0];
                end else begin
                    byte_ready_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        // Chain full: leftover bits of a partial byte are dropped.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (bit_idx_q == 3'd7) begin
                        state_d      = ST_FETCH;
                        byte_ready_d = 1'b1;
                    end else begin
                        bit_idx_d   = bit_idx_q + 3'd1;
                        data_d      = {1'b0, data_q[6:1]};
                        scan_en_d   = 1'b1;
                        shift_stb_d = 1'b1;
                        scan_sdo_d  = data_q[0];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_FETCH) || (state_d == ST_SHIFT);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= 3'd0;
            byte_ready <= 1'b0;
            scan_en    <= 1'b0;
            scan_sdo   <= 1'b0;
            shift_stb  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_ready <= byte_ready_d;
            scan_en    <= scan_en_d;
            scan_sdo   <= scan_sdo_d;
            shift_stb  <= shift_stb_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

    // Remaining bits of the byte being shifted.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    rotfpga2a_cfg_loader_deser u_deser (
        .clk      (clk),
        .rst      (rst),
        .clear    (rb_clear),
        .sample   (rb_sample),
        .last     (rb_last),
        .sdi      (scan_sdi),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

endmodule
